// File: rtl/sync_pkg.sv
// Shared definitions for the PCS code-group synchronisation block:
// FSM state encoding, the seven-bit comma patterns, a comma helper and
// the 10b code-group constants used around the block.
// Code-groups are carried with bit 'a' in the MSB, so a 10-bit
// abcdeifghj group maps to pudi[9:0].
package sync_pkg;

  typedef enum logic [1:0] {
    LOSS_OF_SYNC  = 2'd0,
    COMMA_DETECT  = 2'd1,
    ACQUIRE_SYNC  = 2'd2,
    SYNC_ACQUIRED = 2'd3
  } sync_state_e;

  // Comma = the first seven transmitted bits (a..f plus i).
  localparam int         COMMA_LEN   = 7;
  localparam logic [6:0] COMMA_PLUS  = 7'b0011111;
  localparam logic [6:0] COMMA_MINUS = 7'b1100000;

  // Code-group constants, a-bit in the MSB.
  localparam logic [9:0] K28_5_10B_RD_N = 10'h0FA;  // 001111 1010
  localparam logic [9:0] K28_5_10B_RD_P = 10'h305;  // 110000 0101
  localparam logic [9:0] D16_2_10B_RD_N = 10'h1B5;  // 011011 0101
  localparam logic [9:0] D16_2_10B_RD_P = 10'h245;  // 100100 0101

  function automatic logic is_comma(input logic [COMMA_LEN-1:0] head);
    return (head == COMMA_PLUS) || (head == COMMA_MINUS);
  endfunction

endpackage

// File: rtl/pcs_sync_param_if.sv
// Receive-side bus of the PCS synchroniser: PUDR strobe and code-group in,
// sync status, parity and registered SUDI out. loss_count reads zero unless
// the block is built with SYNC_STATS_EN.
interface pcs_sync_param_if #(
  parameter int CG_WIDTH = 10
) ();

  logic                indicate;
  logic [CG_WIDTH-1:0] pudi;
  logic                cg_valid;
  logic                code_sync_status;
  logic                rx_even;
  logic [CG_WIDTH:0]   sudi;
  logic [15:0]         loss_count;

  modport master (
    output indicate, pudi, cg_valid,
    input  code_sync_status, rx_even, sudi, loss_count
  );

  modport slave (
    input  indicate, pudi, cg_valid,
    output code_sync_status, rx_even, sudi, loss_count
  );

endinterface

// File: rtl/sync_cg_check.sv
// Code-group classifier: comma detection on the leading seven bits and the
// good/bad decision. A comma landing on an odd slot (current rx_even=1)
// is misaligned and therefore bad, as is anything the decoder rejects.
module sync_cg_check
  import sync_pkg::*;
(
  input  logic [COMMA_LEN-1:0] cg_head,
  input  logic                 cg_valid,
  input  logic                 rx_even,
  output logic                 comma,
  output logic                 cgbad,
  output logic                 cggood
);

  assign comma  = is_comma(cg_head);
  assign cgbad  = !cg_valid || (comma && rx_even);
  assign cggood = !cgbad;

endmodule

// File: rtl/pcs_sync_param.sv
// PCS code-group synchroniser. Hunts for commas, requires COMMA_ACQ
// comma/data pairs to declare sync, then tolerates isolated errors:
// LOSS_THRESH net bad code-groups drop sync, and every GOOD_THRESH
// consecutive good ones forgive one bad.
// Build option: define SYNC_STATS_EN to count sync losses on loss_count
// (saturating); otherwise loss_count is tied to zero.
// Parameter ranges: COMMA_ACQ, LOSS_THRESH, GOOD_THRESH in 1..15;
// CG_WIDTH >= 7.
module pcs_sync_param
  import sync_pkg::*;
#(
  parameter int CG_WIDTH    = 10,
  parameter int COMMA_ACQ   = 3,
  parameter int LOSS_THRESH = 4,
  parameter int GOOD_THRESH = 3
) (
  input logic             clk,
  input logic             mr_main_reset_n,
  pcs_sync_param_if.slave bus
);

  localparam int COMMA_W = $clog2(COMMA_ACQ + 1);
  localparam int BAD_W   = $clog2(LOSS_THRESH + 1);
  localparam int GOOD_W  = $clog2(GOOD_THRESH + 1);

  localparam logic [COMMA_W-1:0] COMMA_ACQ_C = COMMA_W'(COMMA_ACQ);
  localparam logic [BAD_W-1:0]   LOSS_C      = BAD_W'(LOSS_THRESH);
  localparam logic [GOOD_W-1:0]  GOOD_C      = GOOD_W'(GOOD_THRESH);

  sync_state_e         state, state_d;
  logic [COMMA_W-1:0]  comma_cnt, comma_cnt_d;
  logic [BAD_W-1:0]    bad_cnt, bad_cnt_d;
  logic [GOOD_W-1:0]   good_cnt, good_cnt_d;
  logic                rx_even, rx_even_d;
  logic                code_sync_status;
  logic [CG_WIDTH:0]   sudi;
  logic                comma, cgbad, cggood;

  sync_cg_check u_cg_check (
    .cg_head  (bus.pudi[CG_WIDTH-1 -: COMMA_LEN]),
    .cg_valid (bus.cg_valid),
    .rx_even  (rx_even),
    .comma    (comma),
    .cgbad    (cgbad),
    .cggood   (cggood)
  );

  // Next state, counters and parity; evaluated only on a PUDR strobe.
  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    state_d     = state;
    comma_cnt_d = comma_cnt;
    bad_cnt_d   = bad_cnt;
    good_cnt_d  = good_cnt;
    rx_even_d   = rx_even;

    if (bus.indicate) begin
      rx_even_d = ~rx_even;
      unique case (state)
        LOSS_OF_SYNC: begin
          if (comma) begin
            state_d     = COMMA_DETECT;
            comma_cnt_d = COMMA_W'(1);
            rx_even_d   = 1'b1;
          end
        end
        COMMA_DETECT: begin
          // A comma must be followed by data; enough pairs seen declares sync.
          if (!bus.cg_valid || comma)       state_d = LOSS_OF_SYNC;
          else if (comma_cnt >= COMMA_ACQ_C) state_d = SYNC_ACQUIRED;
          else                               state_d = ACQUIRE_SYNC;
        end
        ACQUIRE_SYNC: begin
          if (cgbad) begin
            state_d = LOSS_OF_SYNC;
          end else if (comma) begin
            if (comma_cnt < COMMA_ACQ_C) comma_cnt_d = comma_cnt + 1'b1;
            state_d   = COMMA_DETECT;
            rx_even_d = 1'b1;
          end
        end
        SYNC_ACQUIRED: begin
          if (cgbad) begin
            if (bad_cnt + 1'b1 >= LOSS_C) begin
              state_d = LOSS_OF_SYNC;
            end else begin
              bad_cnt_d  = bad_cnt + 1'b1;
              good_cnt_d = '0;
            end
          end else if (cggood && bad_cnt != '0) begin
            if (good_cnt + 1'b1 >= GOOD_C) begin
              bad_cnt_d  = bad_cnt - 1'b1;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt + 1'b1;
            end
          end
        end
        default: state_d = LOSS_OF_SYNC;
      endcase

      // Every path into (or staying in) LOSS_OF_SYNC starts from clean counters.
      if (state_d == LOSS_OF_SYNC) begin
        comma_cnt_d = '0;
        bad_cnt_d   = '0;
        good_cnt_d  = '0;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n) begin
      state            <= LOSS_OF_SYNC;
      comma_cnt        <= '0;
      bad_cnt          <= '0;
      good_cnt         <= '0;
      rx_even          <= 1'b0;
      code_sync_status <= 1'b0;
      sudi             <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples values from before the edge.
      state            <= state_d;
      comma_cnt        <= comma_cnt_d;
      bad_cnt          <= bad_cnt_d;
      good_cnt         <= good_cnt_d;
      rx_even          <= rx_even_d;
      code_sync_status <= (state_d == SYNC_ACQUIRED);
      if (bus.indicate) sudi <= {rx_even_d, bus.pudi};
    end
  end

  assign bus.code_sync_status = code_sync_status;
  assign bus.rx_even          = rx_even;
  assign bus.sudi             = sudi;

`ifdef SYNC_STATS_EN
  logic        sync_lost;
  logic [15:0] loss_count;

  assign sync_lost = bus.indicate && (state == SYNC_ACQUIRED) &&
                     (state_d == LOSS_OF_SYNC);

  // Saturating count of SYNC_ACQUIRED -> LOSS_OF_SYNC transitions.
  always_ff @(posedge clk or negedge mr_main_reset_n) begin
    if (!mr_main_reset_n)                       loss_count <= '0;
    else if (sync_lost && loss_count != 16'hFFFF) loss_count <= loss_count + 16'd1;
  end

  assign bus.loss_count = loss_count;
`else
  assign bus.loss_count = '0;
`endif

endmodule

// File: tb/tb_pcs_sync_param.sv
// Bench for pcs_sync_param: directed table, hand-written corner sequences
// and randomised code-group streams against a behavioural model.
// Two extra instances (LOSS_THRESH=2, COMMA_ACQ=1) share the stimulus.
module tb_pcs_sync_param;
  import sync_pkg::*;

  localparam int W    = 10;
  localparam int ACQ  = 3;
  localparam int LOSS = 4;
  localparam int GOOD = 3;
  localparam logic [9:0] KC = K28_5_10B_RD_N;
  localparam logic [9:0] DC = D16_2_10B_RD_P;
  localparam logic [9:0] XC = 10'h3FF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcs_sync_param_if #(.CG_WIDTH(W)) bus ();
  pcs_sync_param_if #(.CG_WIDTH(W)) bus_l2 ();
  pcs_sync_param_if #(.CG_WIDTH(W)) bus_a1 ();

  assign bus_l2.indicate = bus.indicate;
  assign bus_l2.pudi     = bus.pudi;
  assign bus_l2.cg_valid = bus.cg_valid;
  assign bus_a1.indicate = bus.indicate;
  assign bus_a1.pudi     = bus.pudi;
  assign bus_a1.cg_valid = bus.cg_valid;

  pcs_sync_param #(.CG_WIDTH(W), .COMMA_ACQ(ACQ), .LOSS_THRESH(LOSS), .GOOD_THRESH(GOOD))
    dut (.clk(clk), .mr_main_reset_n(rst_n), .bus(bus));
  pcs_sync_param #(.CG_WIDTH(W), .COMMA_ACQ(ACQ), .LOSS_THRESH(2), .GOOD_THRESH(GOOD))
    dut_l2 (.clk(clk), .mr_main_reset_n(rst_n), .bus(bus_l2));
  pcs_sync_param #(.CG_WIDTH(W), .COMMA_ACQ(1), .LOSS_THRESH(LOSS), .GOOD_THRESH(GOOD))
    dut_a1 (.clk(clk), .mr_main_reset_n(rst_n), .bus(bus_a1));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Sync is described as: hunting (no commas), awaiting data after a comma,
  // or between pairs; once synced, a running error budget.
  bit          m_synced, m_expect, m_even;
  int          m_commas, m_bad, m_good, m_loss;
  logic [W:0]  m_sudi;

  function automatic bit tb_comma(input logic [9:0] p);
    logic [6:0] h;
    h = p[9:3];
    return (h == 7'b0011111) || (h == 7'b1100000);
  endfunction

  function automatic void model_reset();
    m_synced = 0; m_expect = 0; m_even = 0;
    m_commas = 0; m_bad = 0; m_good = 0; m_loss = 0; m_sudi = '0;
  endfunction

  function automatic void model_lose();
    m_synced = 0; m_expect = 0; m_commas = 0; m_bad = 0; m_good = 0;
  endfunction

  function automatic void model_step(input logic [9:0] p, input bit v);
    bit c, bad, ne;
    c   = tb_comma(p);
    bad = !v || (c && m_even);
    ne  = !m_even;
    if (m_synced) begin
      if (bad) begin
        m_good = 0;
        m_bad++;
        if (m_bad == LOSS) begin
          if (m_loss < 65535) m_loss++;
          model_lose();
        end
      end else if (m_bad > 0) begin
        m_good++;
        if (m_good == GOOD) begin m_bad--; m_good = 0; end
      end
    end else if (m_commas == 0) begin
      if (c) begin m_commas = 1; m_expect = 1; ne = 1; end
    end else if (m_expect) begin
      if (!v || c) model_lose();
      else begin m_expect = 0; if (m_commas >= ACQ) m_synced = 1; end
    end else begin
      if (bad) model_lose();
      else if (c) begin
        if (m_commas < ACQ) m_commas++;
        m_expect = 1; ne = 1;
      end
    end
    m_even = ne;
    m_sudi = {ne, p};
  endfunction

  function automatic int exp_loss();
`ifdef SYNC_STATS_EN
    return m_loss;
`else
    return 0;
`endif
  endfunction

  // ---------------- drivers ----------------
  task automatic send(input logic [9:0] p, input bit v);
    @(negedge clk);
    bus.indicate = 1'b1; bus.pudi = p; bus.cg_valid = v;
    @(posedge clk); #1;
    bus.indicate = 1'b0;
    model_step(p, v);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    bus.indicate = 1'b0; bus.pudi = '0; bus.cg_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_model(input string tag);
    check({tag, " sync"},   32'(bus.code_sync_status), 32'(m_synced));
    check({tag, " even"},   32'(bus.rx_even),          32'(m_even));
    check({tag, " sudi"},   32'(bus.sudi),             32'(m_sudi));
    check({tag, " loss"},   32'(bus.loss_count),       exp_loss());
    check({tag, " bad"},    32'(dut.bad_cnt),          m_bad);
    check({tag, " good"},   32'(dut.good_cnt),         m_good);
    check({tag, " commas"}, 32'(dut.comma_cnt),        m_commas);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [9:0] pudi;
    bit         cgv;
    bit         sync;
    bit         even;
    int         bad;
    bit         sync_l2;
    bit         sync_a1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [9:0] p, input bit v, input bit s, input bit e,
                              input int b, input bit s2, input bit s1);
    vec_t r;
    r.pudi = p; r.cgv = v; r.sync = s; r.even = e; r.bad = b; r.sync_l2 = s2; r.sync_a1 = s1;
    return r;
  endfunction

  initial begin
    // Acquisition: three comma/data pairs; rx_even=1 on each comma.
    vecs.push_back(mk(KC, 1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(DC, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(KC, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(DC, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(KC, 1, 0, 1, 0, 0, 1));
    vecs.push_back(mk(DC, 1, 1, 0, 0, 1, 1));
    // One invalid then three valid: bad 1 then back to 0.
    vecs.push_back(mk(XC, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(DC, 1, 1, 0, 1, 1, 1));
    vecs.push_back(mk(DC, 1, 1, 1, 1, 1, 1));
    vecs.push_back(mk(DC, 1, 1, 0, 0, 1, 1));
    // Three invalid (LOSS_THRESH=2 instance drops on the second), nine valid.
    vecs.push_back(mk(XC, 0, 1, 1, 1, 1, 1));
    vecs.push_back(mk(XC, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(XC, 0, 1, 1, 3, 0, 1));
    for (int i = 0; i < 9; i++)
      vecs.push_back(mk(DC, 1, 1, (i % 2 == 1), 3 - (i + 1) / 3, 0, 1));
    // Four invalid: sync lost on the fourth.
    vecs.push_back(mk(XC, 0, 1, 1, 1, 0, 1));
    vecs.push_back(mk(XC, 0, 1, 0, 2, 0, 1));
    vecs.push_back(mk(XC, 0, 1, 1, 3, 0, 1));
    vecs.push_back(mk(XC, 0, 0, 0, 0, 0, 0));

    reset_dut();
    check("reset sync",    32'(bus.code_sync_status), 0);
    check("reset even",    32'(bus.rx_even),          0);
    check("reset sudi",    32'(bus.sudi),             0);
    check("reset loss",    32'(bus.loss_count),       0);
    check("reset l2 sync", 32'(bus_l2.code_sync_status), 0);
    check("reset a1 sync", 32'(bus_a1.code_sync_status), 0);

    foreach (vecs[i]) begin
      send(vecs[i].pudi, vecs[i].cgv);
      check($sformatf("vec%0d sync", i),    32'(bus.code_sync_status),    32'(vecs[i].sync));
      check($sformatf("vec%0d even", i),    32'(bus.rx_even),             32'(vecs[i].even));
      check($sformatf("vec%0d sudi", i),    32'(bus.sudi),                32'({vecs[i].even, vecs[i].pudi}));
      check($sformatf("vec%0d bad", i),     32'(dut.bad_cnt),             vecs[i].bad);
      check($sformatf("vec%0d l2 sync", i), 32'(bus_l2.code_sync_status), 32'(vecs[i].sync_l2));
      check($sformatf("vec%0d a1 sync", i), 32'(bus_a1.code_sync_status), 32'(vecs[i].sync_a1));
    end
`ifdef SYNC_STATS_EN
    check("table loss_count", 32'(bus.loss_count), 1);
`else
    check("table loss_count", 32'(bus.loss_count), 0);
`endif

    // Misaligned comma during ACQUIRE_SYNC drops to LOSS_OF_SYNC.
    reset_dut();
    send(KC, 1);
    check("odd comma cnt1", 32'(dut.comma_cnt), 1);
    send(DC, 1);
    send(DC, 1);
    check("odd comma even", 32'(bus.rx_even), 1);
    send(K28_5_10B_RD_P, 1);
    check("odd comma sync",  32'(bus.code_sync_status), 0);
    check("odd comma cnt0",  32'(dut.comma_cnt),        0);
    check("odd comma even0", 32'(bus.rx_even),          0);
    check("odd comma state", 32'(dut.state),            32'(LOSS_OF_SYNC));

    // Asynchronous reset in the middle of SYNC_ACQUIRED.
    reset_dut();
    for (int i = 0; i < 3; i++) begin send(KC, 1); send(DC, 1); end
    check("pre-reset sync", 32'(bus.code_sync_status), 1);
    send(XC, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async rst sync", 32'(bus.code_sync_status), 0);
    check("async rst even", 32'(bus.rx_even),          0);
    check("async rst sudi", 32'(bus.sudi),             0);
    check("async rst loss", 32'(bus.loss_count),       0);
    check("async rst bad",  32'(dut.bad_cnt),          0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    send(DC, 1);
    check_model("post-rst data");
    send(KC, 1);
    check_model("post-rst comma");

    // Randomised streams: commas favoured on even slots, data on odd slots.
    reset_dut();
    for (int k = 0; k < 1500; k++) begin
      int         r;
      logic [9:0] p;
      bit         v;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
        check($sformatf("rnd%0d hold sudi", k), 32'(bus.sudi), 32'(m_sudi));
      end
      r = $urandom_range(0, 99);
      v = 1'b1;
      if ((k % 2 == 0) ? (r < 55) : (r < 5))
        p = $urandom_range(0, 1) ? K28_5_10B_RD_N : K28_5_10B_RD_P;
      else if ((k % 2 == 0) ? (r < 88) : (r < 92))
        p = $urandom_range(0, 1) ? 10'($urandom) : ($urandom_range(0, 1) ? DC : D16_2_10B_RD_N);
      else begin
        p = 10'($urandom);
        v = 1'b0;
      end
      send(p, v);
      check_model($sformatf("rnd%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
